// File: rtl/serdes_pkg.sv
// ============================================================================
// serdes_pkg -- shared state encoding, bit-order constants and bit selection
// Rev 1.0
// ============================================================================
`default_nettype none

package serdes_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic ORDER_MSB_FIRST = 1'b0;
  localparam logic ORDER_LSB_FIRST = 1'b1;

  localparam int unsigned MAX_WIDTH = 64;

  // width is taken modulo 64; the wrap keeps a 64-bit word selecting correctly.
  function automatic logic bit_select(input logic [MAX_WIDTH-1:0] word,
                                      input logic [5:0]           width,
                                      input logic                 order,
                                      input logic [5:0]           k);
    logic [5:0] idx;
    if (order == ORDER_LSB_FIRST) begin
      idx = k;
    end else begin
      idx = width - 6'd1 - k;
    end
    return word[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_hold_buf.sv
// ============================================================================
// piso_hold_buf -- one-entry pending word register with full flag
// Rev 1.0
// ============================================================================
`default_nettype none

module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             take_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             full_d, full_q;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (take_en) begin
      full_d = 1'b0;
    end
    if (load_en) begin
      full_d = 1'b1;
      data_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer -- parallel-in serial-out transmitter, gapless back-to-back
// Rev 1.0
// ============================================================================
`default_nettype none

module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic             ORDER = LSB_FIRST ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] word_d, word_q;
  logic             ser_out_d, ser_out_q;
  logic             ser_valid_d, ser_valid_q;
  logic             ser_first_d, ser_first_q;
  logic             ser_last_d, ser_last_q;

  logic             accept;
  logic             pend_load;
  logic             pend_take;
  logic             pend_full;
  logic [WIDTH-1:0] pend_data;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_en (pend_load),
    .take_en (pend_take),
    .din     (load_data),
    .dout    (pend_data),
    .full    (pend_full)
  );

  assign load_ready = !rst && !pend_full;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    pend_load = 1'b0;
    pend_take = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          word_d  = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d     = cnt_q + 1'b1;
          pend_load = accept;
        end else if (pend_full) begin
          word_d    = pend_data;
          cnt_d     = '0;
          pend_take = 1'b1;
        end else if (accept) begin
          // Last-bit edge with nothing pending: new word skips the buffer.
          word_d = load_data;
          cnt_d  = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so bit 0 appears one edge after accept.
  always_comb begin
    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = IDLE_LEVEL;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    if (ser_valid_d) begin
      ser_out_d   = bit_select(MAX_WIDTH'(word_d), 6'(WIDTH), ORDER, 6'(cnt_d));
      ser_first_d = (cnt_d == '0);
      ser_last_d  = (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q == SHIFT) || pend_full;

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It produces the single-bit serial stream that the team's serial shift-register chains consume.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- A one-entry pending buffer allows back-to-back words with no idle bit between them.
- Sits between a word-oriented producer and any serial link or shift chain in the design.

Parameters:
- WIDTH, 4: bits per word; must be >= 2.
- LSB_FIRST, 0: 0 sends the MSB first, 1 sends the LSB first.
- IDLE_LEVEL, 0: level driven on ser_out when no word is being sent.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data, registered.
- ser_valid  output  1  ser_out carries a data bit, registered.
- ser_first  output  1  current bit is the first bit of a word, registered.
- ser_last  output  1  current bit is the last bit of a word, registered.
- busy  output  1  shifting, or pending buffer occupied.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state after any edge with rst=1:
  - state=IDLE, pending buffer empty, bit counter=0.
  - ser_out=IDLE_LEVEL; ser_valid=0, ser_first=0, ser_last=0, busy=0.
- load_ready = !rst && !pend_full (combinational). A word is accepted only on an edge where load_valid && load_ready.
- States: IDLE and SHIFT. A bit counter runs 0..WIDTH-1, width clog2(WIDTH).
- IDLE:
  - On accept, go to SHIFT. The shift register loads the word and the counter is set to 0.
  - Latency is 1 edge: bit 0 appears on ser_out with ser_valid=1 and ser_first=1 in the cycle after the accept edge.
- SHIFT, edges with counter < WIDTH-1:
  - Counter increments and the next bit is driven.
  - An accept in this state writes into the pending buffer.
- SHIFT, edge with counter == WIDTH-1 (last bit on the wire, ser_last=1):
  - If pending is full: the pending word moves into the shifter, counter=0, pending clears, and the state stays SHIFT. There is no gap.
  - Else, if an accept happens on this edge: the new word bypasses pending straight into the shifter, counter=0, and the state stays SHIFT. There is no gap.
  - Else: go to IDLE. In the next cycle ser_valid=0 and ser_out=IDLE_LEVEL.
- Bit order:
  - MSB first: bit k sent is word[WIDTH-1-k].
  - LSB first: bit k sent is word[k].
- Simultaneous events:
  - Accept while pending is full is impossible, because ready=0.
  - Transfer from pending and a new accept cannot share an edge.
  - load_ready rises the cycle after pending empties.
- Reset mid-word or mid-pending:
  - The current word and the pending word are discarded. No further bits are sent.
  - Outputs take their reset values on the next edge.
  - Accepts presented while rst=1 are ignored.
- No back-pressure on the serial side: once started, a word always completes unless reset.

Decomposition:
- Shared package serdes_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the bit-order constants (MSB_FIRST=0, LSB_FIRST=1);
  - a bit-select function returning the k-th transmitted bit given WIDTH and order.
- Optional sub-module piso_hold_buf: the one-entry pending register with full flag and load/take controls. All other logic is inline.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles with load_valid=1.
   - Response: load_ready=0, ser_valid=0, ser_out=0, busy=0. After rst drops, load_ready=1 and no word has been captured.
2. Single word:
   - Stimulus: WIDTH=4, MSB first, 4'b1011 accepted at edge N.
   - Response: ser_out=1,0,1,1 in cycles N+1..N+4 with ser_valid=1; ser_first only in the 1st cycle, ser_last only in the 4th. ser_valid=0 at N+5.
3. Back-to-back through pending:
   - Stimulus: 4'hA accepted, then 4'h5 presented during the 2nd bit.
   - Response: 4'h5 goes to pending and load_ready=0 until the transfer edge. Serial stream is 1,0,1,0,0,1,0,1 with ser_valid continuously high for 8 cycles.
4. Bypass on the last-bit edge:
   - Stimulus: pending empty; 4'h3 presented exactly on the edge where 4'hC's last bit is on the wire.
   - Response: stream is 1,1,0,0,0,0,1,1 with no gap, and pending is never set.
5. LSB first:
   - Stimulus: LSB_FIRST=1, WIDTH=8, 8'h01 accepted.
   - Response: ser_out=1,0,0,0,0,0,0,0; ser_last on the 8th bit.
6. Reset mid-word:
   - Stimulus: 4'hF accepted, 4'h9 pending; rst pulsed after the 2nd bit.
   - Response: ser_valid=0 the next cycle, busy=0, no remaining bits of either word emitted. A subsequent 4'h6 transmits as 0,1,1,0.
